// File: rtl/led_chaser_sequencer.sv
// rtl/led_chaser_sequencer.sv - 8-LED chaser sequencer: prescaled fill-left, fill-right, blink playlist
// NEXT skips straight to the following effect's entry value and restarts the step timebase.
module led_chaser_sequencer #(
   parameter int DIV       = 4,
   parameter int BLINK_CNT = 3
) (
   input  logic       Clk,
   input  logic       RST,
   input  logic       SS,
   input  logic       NEXT,
   output logic [7:0] LED,
   output logic [1:0] EFFECT,
   output logic       STEP_TICK,
   output logic       DONE
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FILL_L = 2'd1,
      FILL_R = 2'd2,
      BLINK  = 2'd3
   } effect_t;

   localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
   localparam int BW = (BLINK_CNT > 1) ? $clog2(BLINK_CNT) : 1;
   localparam logic [PW-1:0] PRESC_LAST = PW'(DIV - 1);
   localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CNT - 1);

   effect_t       effect_q, effect_d;
   logic [7:0]    led_q, led_d;
   logic [PW-1:0] presc_q, presc_d;
   logic [BW-1:0] bcnt_q, bcnt_d;
   logic          next_q, next_d;
   logic          done_q, done_d;
   logic          nedge;
   logic          tick;

   assign nedge     = NEXT && !next_q;
   assign tick      = SS && (presc_q == PRESC_LAST);
   assign STEP_TICK = tick;
   assign LED       = led_q;
   assign EFFECT    = effect_q;
   assign DONE      = done_q;

   always_comb begin
      effect_d = effect_q;
      led_d    = led_q;
      presc_d  = presc_q;
      bcnt_d   = bcnt_q;
      next_d   = NEXT;
      done_d   = 1'b0;

      if (nedge) begin
         // A skip wins over a coincident tick and restarts the timebase.
         presc_d = '0;
         bcnt_d  = '0;
         case (effect_q)
            IDLE, BLINK: begin
               effect_d = FILL_L;
               led_d    = 8'h01;
            end
            FILL_L: begin
               effect_d = FILL_R;
               led_d    = 8'h80;
            end
            FILL_R: begin
               effect_d = BLINK;
               led_d    = 8'h00;
            end
            default: begin
               effect_d = IDLE;
               led_d    = 8'h00;
            end
         endcase
      end else if (tick) begin
         presc_d = '0;
         case (effect_q)
            IDLE: begin
               effect_d = FILL_L;
               led_d    = 8'h01;
            end
            FILL_L: begin
               if (led_q != 8'hFF) begin
                  led_d = {led_q[6:0], 1'b1};
               end else begin
                  effect_d = FILL_R;
                  led_d    = 8'h80;
               end
            end
            FILL_R: begin
               if (led_q != 8'hFF) begin
                  led_d = {1'b1, led_q[7:1]};
               end else begin
                  effect_d = BLINK;
                  led_d    = 8'h00;
                  bcnt_d   = '0;
               end
            end
            BLINK: begin
               if (led_q == 8'h00) begin
                  led_d = 8'hFF;
               end else if (bcnt_q == BLINK_LAST) begin
                  // Only a natural end of the blink phase counts as a completed loop.
                  effect_d = FILL_L;
                  led_d    = 8'h01;
                  bcnt_d   = '0;
                  done_d   = 1'b1;
               end else begin
                  led_d  = 8'h00;
                  bcnt_d = bcnt_q + BW'(1);
               end
            end
            default: begin
               effect_d = IDLE;
               led_d    = 8'h00;
            end
         endcase
      end else if (SS) begin
         presc_d = presc_q + PW'(1);
      end
   end

   always_ff @(posedge Clk or posedge RST) begin
      if (RST) begin
         effect_q <= IDLE;
         led_q    <= 8'h00;
         presc_q  <= '0;
         bcnt_q   <= '0;
         next_q   <= 1'b0;
         done_q   <= 1'b0;
      end else begin
         effect_q <= effect_d;
         led_q    <= led_d;
         presc_q  <= presc_d;
         bcnt_q   <= bcnt_d;
         next_q   <= next_d;
         done_q   <= done_d;
      end
   end

endmodule

// File: tb/tb_led_chaser_sequencer.sv
// tb/tb_led_chaser_sequencer.sv - randomized bench for led_chaser_sequencer against a playlist-index model
// Two instances (DIV=4/BLINK_CNT=3 and DIV=1/BLINK_CNT=2) share one stimulus stream.
module tb_led_chaser_sequencer;

   logic       Clk;
   logic       RST;
   logic       SS;
   logic       NEXT;
   logic [7:0] led0, led1;
   logic [1:0] eff0, eff1;
   logic       tick0, tick1;
   logic       done0, done1;

   int n_chk = 0;
   int n_bad = 0;

   // Model: position in one unrolled loop of the playlist, plus timebase and edge detector.
   int m_idle [2];
   int m_pos  [2];
   int m_presc[2];
   int m_nq   [2];
   int m_done [2];

   led_chaser_sequencer #(.DIV(4), .BLINK_CNT(3)) u_dut0 (
      .Clk(Clk), .RST(RST), .SS(SS), .NEXT(NEXT),
      .LED(led0), .EFFECT(eff0), .STEP_TICK(tick0), .DONE(done0)
   );

   led_chaser_sequencer #(.DIV(1), .BLINK_CNT(2)) u_dut1 (
      .Clk(Clk), .RST(RST), .SS(SS), .NEXT(NEXT),
      .LED(led1), .EFFECT(eff1), .STEP_TICK(tick1), .DONE(done1)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic int div_of(int k);
      return (k == 0) ? 4 : 1;
   endfunction

   function automatic int bc_of(int k);
      return (k == 0) ? 3 : 2;
   endfunction

   function automatic logic [7:0] exp_led(int k);
      int p;
      int v;
      p = m_pos[k];
      if (m_idle[k] != 0) v = 0;
      else if (p < 8)     v = (1 << (p + 1)) - 1;
      else if (p < 16)    v = (255 << (15 - p)) & 255;
      else                v = (((p - 16) % 2) == 1) ? 255 : 0;
      return v[7:0];
   endfunction

   function automatic logic [1:0] exp_eff(int k);
      if (m_idle[k] != 0)  return 2'd0;
      if (m_pos[k] < 8)    return 2'd1;
      if (m_pos[k] < 16)   return 2'd2;
      return 2'd3;
   endfunction

   function automatic logic exp_tick(int k);
      return SS && (m_presc[k] == div_of(k) - 1);
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 2; k++) begin
         m_idle[k]  = 1;
         m_pos[k]   = 0;
         m_presc[k] = 0;
         m_nq[k]    = 0;
         m_done[k]  = 0;
      end
   endtask

   task automatic model_step(int k);
      int len;
      logic ne;
      logic tk;
      len = 16 + 2 * bc_of(k);
      ne  = NEXT && (m_nq[k] == 0);
      tk  = exp_tick(k);
      m_done[k] = 0;
      if (ne) begin
         if (m_idle[k] != 0)   m_pos[k] = 0;
         else if (m_pos[k] < 8)  m_pos[k] = 8;
         else if (m_pos[k] < 16) m_pos[k] = 16;
         else                    m_pos[k] = 0;
         m_idle[k]  = 0;
         m_presc[k] = 0;
      end else if (tk) begin
         m_presc[k] = 0;
         if (m_idle[k] != 0) begin
            m_idle[k] = 0;
            m_pos[k]  = 0;
         end else if (m_pos[k] == len - 1) begin
            m_pos[k]  = 0;
            m_done[k] = 1;
         end else begin
            m_pos[k] = m_pos[k] + 1;
         end
      end else if (SS) begin
         m_presc[k] = m_presc[k] + 1;
      end
      m_nq[k] = NEXT ? 1 : 0;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
      end
   endtask

   task automatic check_outputs();
      check("led0",  {24'd0, led0},  {24'd0, exp_led(0)});
      check("eff0",  {30'd0, eff0},  {30'd0, exp_eff(0)});
      check("done0", {31'd0, done0}, {31'd0, m_done[0] != 0});
      check("led1",  {24'd0, led1},  {24'd0, exp_led(1)});
      check("eff1",  {30'd0, eff1},  {30'd0, exp_eff(1)});
      check("done1", {31'd0, done1}, {31'd0, m_done[1] != 0});
   endtask

   initial begin
      int dones;
      RST  = 1'b1;
      SS   = 1'b0;
      NEXT = 1'b0;
      dones = 0;
      model_reset();
      repeat (2) @(negedge Clk);
      check("rst_led0", {24'd0, led0}, 32'h00);
      check("rst_eff0", {30'd0, eff0}, 32'h0);
      check("rst_done0", {31'd0, done0}, 32'h0);
      check("rst_led1", {24'd0, led1}, 32'h00);
      RST = 1'b0;
      SS  = 1'b1;

      for (int cyc = 0; cyc < 3000; cyc++) begin
         @(posedge Clk);
         model_step(0);
         model_step(1);
         @(negedge Clk);
         check_outputs();
         if (cyc < 100 && done0) dones++;
         if (cyc == 100) check("loop_done_count", dones, 1);
         if (cyc >= 100) begin
            SS = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 7) == 0) NEXT = !NEXT;
         end
         #1;
         check("tick0", {31'd0, tick0}, {31'd0, exp_tick(0)});
         check("tick1", {31'd0, tick1}, {31'd0, exp_tick(1)});
         if (cyc >= 100 && $urandom_range(0, 149) == 0) begin
            RST = 1'b1;
            #1;
            check("async_led0", {24'd0, led0}, 32'h00);
            check("async_eff0", {30'd0, eff0}, 32'h0);
            check("async_led1", {24'd0, led1}, 32'h00);
            check("async_eff1", {30'd0, eff1}, 32'h0);
            model_reset();
            #1;
            RST = 1'b0;
         end
      end

      $display("test done: total=%0d bad=%0d", n_chk, n_bad);
      $finish;
   end

endmodule

// File: doc/led_chaser_sequencer.md
# led_chaser_sequencer

Sequencer for the 8-LED chaser board: owns the step timebase and steps the LED bank through a fixed effect playlist: fill-from-LSB, fill-from-MSB, then whole-bank blink. The sequence repeats indefinitely. Sits between the board clock/pushbuttons and the LED pins. It gives the simple fill-chaser a prescaled step rate, a skip control and an end-of-loop indication.

## Interface
- DIV, default 4: clock cycles per step tick; legal range ≥1 (board build uses 50_000_000).
- BLINK_CNT, default 3: number of all-on phases in the blink effect; legal range ≥1.
- Clk  in  1  single system clock; all state changes on its rising edge.
- RST  in  1  asynchronous, active-high reset; clears all state immediately.
- SS  in  1  run enable (level); 1 = prescaler counts and steps advance, 0 = freeze.
- NEXT  in  1  skip request, already synchronised/debounced; acted on at its rising edge.
- LED  out  8  LED bank drive, registered.
- EFFECT  out  2  current state: 0 IDLE, 1 FILL_L, 2 FILL_R, 3 BLINK, registered.
- STEP_TICK  out  1  combinational; high in the cycle whose closing edge applies a step.
- DONE  out  1  registered one-cycle pulse marking completion of a full playlist loop.

## Operation
- Reset values: LED=8'h00, EFFECT=0 (IDLE), DONE=0, prescaler=0, blink counter=0, NEXT edge register=0.
- Prescaler: counts 0..DIV-1 only while SS=1, and holds its value while SS=0. STEP_TICK = SS && (prescaler==DIV-1). On a tick the prescaler wraps to 0. The prescaler width is $clog2(DIV), minimum 1 bit.
- NEXT edge: nedge = NEXT && !NEXT_q, where NEXT_q is registered every cycle regardless of SS. If NEXT is held high through reset release, an edge is produced on the first clock.
- On each tick:
  - IDLE -> FILL_L, LED=8'h01.
  - FILL_L:
    - LED!=FF: LED={LED[6:0],1'b1}.
    - LED==FF: -> FILL_R, LED=8'h80.
  - FILL_R:
    - LED!=FF: LED={1'b1,LED[7:1]}.
    - LED==FF: -> BLINK, LED=8'h00, blink counter=0.
  - BLINK:
    - LED==00: LED=FF.
    - LED==FF and blink counter==BLINK_CNT-1: -> FILL_L, LED=01, blink counter=0, DONE=1 next cycle.
    - LED==FF otherwise: LED=00, blink counter+1.
- On nedge, the block jumps immediately to the next effect's entry value: IDLE->FILL_L(01), FILL_L->FILL_R(80), FILL_R->BLINK(00), BLINK->FILL_L(01). The blink counter is cleared and the prescaler is cleared to 0. This works regardless of SS. A NEXT-caused wrap does not pulse DONE.
- Simultaneous nedge and tick: nedge wins and the tick is discarded (exactly one transition).
- SS=0: LED, EFFECT and counters hold; no ticks and no DONE.
- Loop period from FILL_L entry back to FILL_L entry is 16 + 2*BLINK_CNT ticks (22 at default).

## Timing
- LED and EFFECT update on the Clk edge that closes a STEP_TICK cycle or an nedge cycle; zero added latency.
- From SS rising (prescaler=0), the first step is applied at the DIV-th rising edge. With DIV=1, the block steps every cycle while SS=1.
- DONE is high for exactly the one cycle following the BLINK->FILL_L wrap edge, i.e. coincident with the first cycle of LED==01.
- RST assertion mid-step forces the reset values asynchronously. After release, the first tick again needs DIV enabled cycles.
- Each tick applies exactly one state/LED update.

## Test plan
- Reset, SS=1, DIV=4: LED stays 00 for 3 edges, 01 at the 4th edge, then 03, 07 … FF at 4-cycle spacing; EFFECT=1.
- Continue with SS=1: FF->80 (EFFECT=2), C0 … FF, ->00 (EFFECT=3), blink sequence 00,FF,00,FF,00,FF, then 01 with a single-cycle DONE; the full loop is 22 ticks.
- Drop SS while LED=07 with prescaler=2, hold 10 cycles, raise SS: LED stays 07 throughout; 0F appears 2 edges after SS returns.
- Pulse NEXT in FILL_L (LED=07): LED=80, EFFECT=2 next edge, prescaler=0, no DONE. Hold NEXT high for 5 cycles: only one skip occurs.
- Assert NEXT rising in the same cycle as STEP_TICK in FILL_R: a single transition to BLINK with LED=00.
- Assert RST asynchronously mid-BLINK (LED=FF, between edges): LED=00 and EFFECT=0 immediately. With DIV=1 after release, LED=01 at the first edge.
